// File: rtl/router_pkg.sv
// Shared types and header-field helpers for the router packet register.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DROP  = 2'd3
  } state_e;

  localparam int STATS_W   = 16;
  localparam int HDR_MAX_W = 32;

  // Header layout: {length, address}; the address occupies the low addr_w bits.
  function automatic int hdr_addr(input logic [HDR_MAX_W-1:0] word, input int addr_w);
    return int'(word & ((32'd1 << addr_w) - 32'd1));
  endfunction

  function automatic int hdr_len(input logic [HDR_MAX_W-1:0] word, input int addr_w);
    return int'(word >> addr_w);
  endfunction

endpackage

// File: rtl/router_skid_buf.sv
// Two-entry skid buffer: registered output stage plus one hold entry.
// Handshake: a word moves when valid && ready on the same rising edge; valid never drops without a transfer.
module router_skid_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;
  logic              out_fire;

  assign in_ready = !hold_valid;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (hold_valid) begin
      // Input is blocked while hold is occupied; hold moves forward on the next transfer.
      if (out_fire) begin
        out_data   <= hold_data;
        hold_valid <= 1'b0;
      end
    end else if (in_valid) begin
      if (!out_valid || out_fire) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else begin
        hold_data  <= in_data;
        hold_valid <= 1'b1;
      end
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/router_pkt_reg.sv
// Packet register/checker: header decode, skid-buffered forwarding, XOR parity and length check.
// Optional statistics counters are built when ROUTER_PKT_STATS_EN is defined.
module router_pkt_reg
  import router_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  output logic              busy,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [ADDR_W-1:0] dest,
  output logic              dest_valid,
  output logic              parity_done,
  output logic              err,
  output logic              len_err,
  output logic              drop
`ifdef ROUTER_PKT_STATS_EN
  ,
  output logic [STATS_W-1:0] pkt_cnt,
  output logic [STATS_W-1:0] err_cnt,
  output logic [STATS_W-1:0] drop_cnt
`endif
);

  localparam int LEN_W = DATA_W - ADDR_W;
  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  state_e state_q, state_d;

  logic              skid_ready;
  logic              accept;
  logic              hdr_accept;
  logic              fwd;
  logic              hdr_ok;
  int                hdr_addr_i;
  int                hdr_len_i;
  logic [DATA_W-1:0] parity_q;
  logic [DATA_W-1:0] pkt_par_q;
  logic [LEN_W-1:0]  count_q;
  logic [LEN_W-1:0]  len_q;
  logic              err_q;
  logic              len_err_q;
  logic              chk_err;
  logic              chk_len_err;

  always_comb begin
    hdr_addr_i = hdr_addr(HDR_MAX_W'(data_in), ADDR_W);
    hdr_len_i  = hdr_len(HDR_MAX_W'(data_in), ADDR_W);
    hdr_ok     = hdr_addr_i < NUM_CH;
  end

  // A word is consumed only when the hold entry is free and the FSM is in a word-taking state.
  assign accept = skid_ready &&
                  ((state_q == IDLE && pkt_valid) || state_q == LOAD || state_q == DROP);
  assign hdr_accept = accept && state_q == IDLE;
  assign fwd        = (hdr_accept && hdr_ok) || (accept && state_q == LOAD);

  assign busy = !skid_ready;

  router_skid_buf #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clock    (clock),
    .resetn   (resetn),
    .in_valid (fwd),
    .in_data  (data_in),
    .in_ready (skid_ready),
    .out_valid(dout_valid),
    .out_data (dout),
    .out_ready(!fifo_full)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (hdr_accept) state_d = hdr_ok ? LOAD : DROP;
      LOAD:  if (accept && !pkt_valid) state_d = CHECK;
      CHECK: state_d = IDLE;
      DROP:  if (accept && !pkt_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign chk_err     = parity_q != pkt_par_q;
  assign chk_len_err = count_q != len_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      parity_q  <= '0;
      pkt_par_q <= '0;
      count_q   <= '0;
      len_q     <= '0;
      dest      <= '0;
      err_q     <= 1'b0;
      len_err_q <= 1'b0;
      drop      <= 1'b0;
    end else begin
      drop <= hdr_accept && !hdr_ok;
      if (hdr_accept && hdr_ok) begin
        parity_q  <= data_in;
        count_q   <= '0;
        len_q     <= LEN_W'(hdr_len_i);
        dest      <= ADDR_W'(hdr_addr_i);
        err_q     <= 1'b0;
        len_err_q <= 1'b0;
      end
      if (accept && state_q == LOAD) begin
        if (pkt_valid) begin
          parity_q <= parity_q ^ data_in;
          if (count_q != CNT_MAX) count_q <= count_q + LEN_W'(1);
        end else begin
          pkt_par_q <= data_in;
        end
      end
      // Results are shown live during CHECK and latched here until the next header.
      if (state_q == CHECK) begin
        err_q     <= chk_err;
        len_err_q <= chk_len_err;
      end
    end
  end

  assign parity_done = state_q == CHECK;
  assign dest_valid  = state_q == LOAD || state_q == CHECK;
  assign err         = (state_q == CHECK) ? chk_err : err_q;
  assign len_err     = (state_q == CHECK) ? chk_len_err : len_err_q;

`ifdef ROUTER_PKT_STATS_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pkt_cnt  <= '0;
      err_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (parity_done && pkt_cnt != '1) pkt_cnt <= pkt_cnt + 1'b1;
      if (parity_done && (err || len_err) && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_router_pkt_reg.sv
// Bench for router_pkt_reg: directed packets, back-pressure, reset mid-packet, random traffic.
module tb_router_pkt_reg;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       fifo_full = 1'b0;
  logic       busy, dout_valid, dest_valid, parity_done, err, len_err, drop;
  logic [7:0] dout;
  logic [1:0] dest;
`ifdef ROUTER_PKT_STATS_EN
  logic [15:0] pkt_cnt, err_cnt, drop_cnt;
`endif

  router_pkt_reg #(.DATA_W(8), .NUM_CH(3), .ADDR_W(2)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .pkt_valid  (pkt_valid),
    .data_in    (data_in),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dest       (dest),
    .dest_valid (dest_valid),
    .parity_done(parity_done),
    .err        (err),
    .len_err    (len_err),
    .drop       (drop)
`ifdef ROUTER_PKT_STATS_EN
    ,
    .pkt_cnt    (pkt_cnt),
    .err_cnt    (err_cnt),
    .drop_cnt   (drop_cnt)
`endif
  );

  // clock / reset
  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         pd_seen = 0;
  int         drop_seen = 0;
  int         out_cnt = 0;
  logic       busy_seen = 1'b0;
  logic       exp_err = 1'b0;
  logic       exp_len_err = 1'b0;
  logic [1:0] exp_dest = 2'd0;
  logic       rand_bp = 1'b0;
  logic [7:0] pl[16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clock) begin
    if (resetn) begin
      if (dout_valid && !fifo_full) begin
        out_cnt++;
        if (exp_q.size() == 0) check("dout_unexpected", 32'(exp_q.size() != 0), 32'd1);
        else                   check("dout", 32'(dout), 32'(exp_q.pop_front()));
      end
      if (busy) busy_seen = 1'b1;
      if (dest_valid) check("dest", 32'(dest), 32'(exp_dest));
      if (parity_done) begin
        pd_seen++;
        check("err", 32'(err), 32'(exp_err));
        check("len_err", 32'(len_err), 32'(exp_len_err));
      end
      if (drop) drop_seen++;
    end
  end

  // random back-pressure source
  initial begin
    forever begin
      @(posedge clock);
      #2;
      if (rand_bp) fifo_full = ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // driver: hold word until a rising edge with busy low consumes it
  task automatic drive_word(input logic pv, input logic [7:0] d);
    int   guard;
    logic was_busy;
    guard = 0;
    pkt_valid = pv;
    data_in = d;
    do begin
      @(negedge clock);
      was_busy = busy;
      cycle();
      guard++;
    end while (was_busy && guard < 200);
    if (was_busy) check("drive_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      cycle();
      guard++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_packet(input logic [7:0] hdr, input int n, input logic [7:0] par);
    int         pd0, dr0;
    logic       fwd;
    logic [7:0] x;
    pd0 = pd_seen;
    dr0 = drop_seen;
    fwd = hdr[1:0] < 2'd3;
    x = hdr;
    for (int i = 0; i < n; i++) x = x ^ pl[i];
    if (fwd) begin
      exp_dest    = hdr[1:0];
      exp_err     = (x != par);
      exp_len_err = (n != int'(hdr[7:2]));
      exp_q.push_back(hdr);
    end
    drive_word(1'b1, hdr);
    for (int i = 0; i < n; i++) begin
      if (fwd) exp_q.push_back(pl[i]);
      drive_word(1'b1, pl[i]);
    end
    if (fwd) exp_q.push_back(par);
    drive_word(1'b0, par);
    data_in = 8'h00;
    wait_drain();
    repeat (3) cycle();
    check("parity_done_cnt", 32'(pd_seen - pd0), fwd ? 32'd1 : 32'd0);
    check("drop_cnt", 32'(drop_seen - dr0), fwd ? 32'd0 : 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    @(negedge clock);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_dout"}, 32'(dout), 32'd0);
    check({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
    check({tag, "_dest"}, 32'(dest), 32'd0);
    check({tag, "_dest_valid"}, 32'(dest_valid), 32'd0);
    check({tag, "_parity_done"}, 32'(parity_done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_len_err"}, 32'(len_err), 32'd0);
    check({tag, "_drop"}, 32'(drop), 32'd0);
  endtask

  task automatic load_std();
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
  endtask

  initial begin
    int o0, len, n, ch;
    logic [7:0] x, hdr;

    check_outputs_zero("reset");
    cycle();
    resetn = 1'b1;
    repeat (2) cycle();

    // 1: good packet to channel 1
    load_std();
    o0 = out_cnt;
    run_packet(8'h0D, 3, 8'h0D);
    check("t1_words_out", 32'(out_cnt - o0), 32'd5);

    // 2: bad parity, err held afterwards
    run_packet(8'h0D, 3, 8'h00);
    repeat (3) cycle();
    check("t2_err_held", 32'(err), 32'd1);

    // 3: one payload word too many, parity over all four
    run_packet(8'h0D, 4, 8'h49);
    check("t3_len_err_held", 32'(len_err), 32'd1);
    check("t3_err_cleared", 32'(err), 32'd0);

    // 4: dropped header, then valid packet still forwarded
    o0 = out_cnt;
    run_packet(8'h07, 1, 8'h07 ^ 8'h11);
    check("t4_no_dout", 32'(out_cnt - o0), 32'd0);
    run_packet(8'h0E, 3, 8'h0E ^ 8'h11 ^ 8'h22 ^ 8'h33);

    // 5: four cycles of fifo_full mid-payload
    for (int i = 0; i < 6; i++) pl[i] = 8'hA0 + 8'(i);
    x = 8'h1A;
    for (int i = 0; i < 6; i++) x = x ^ pl[i];
    busy_seen = 1'b0;
    o0 = out_cnt;
    fork
      run_packet(8'h1A, 6, x);
      begin
        int guard;
        guard = 0;
        while (out_cnt < o0 + 2 && guard < 100) begin
          cycle();
          guard++;
        end
        fifo_full = 1'b1;
        repeat (4) cycle();
        fifo_full = 1'b0;
      end
    join
    check("t5_busy_seen", 32'(busy_seen), 32'd1);
    check("t5_words_out", 32'(out_cnt - o0), 32'd8);

    // 6: reset in the middle of LOAD
    load_std();
    exp_dest = 2'd1;
    exp_q.push_back(8'h0D);
    drive_word(1'b1, 8'h0D);
    exp_q.push_back(8'h11);
    drive_word(1'b1, 8'h11);
    exp_q.push_back(8'h22);
    drive_word(1'b1, 8'h22);
    resetn = 1'b0;
    pkt_valid = 1'b0;
    exp_q.delete();
    check_outputs_zero("midreset");
    repeat (2) cycle();
    resetn = 1'b1;
    repeat (2) cycle();
    run_packet(8'h0D, 3, 8'h0D);
`ifdef ROUTER_PKT_STATS_EN
    check("stats_pkt_cnt", 32'(pkt_cnt), 32'd1);
    check("stats_err_cnt", 32'(err_cnt), 32'd0);
    check("stats_drop_cnt", 32'(drop_cnt), 32'd0);
`endif

    // 7: random packets under random back-pressure
    rand_bp = 1'b1;
    for (int p = 0; p < 6; p++) begin
      ch  = $urandom_range(0, 3);
      len = $urandom_range(1, 5);
      n   = ($urandom_range(0, 3) == 0) ? len + 1 : len;
      hdr = {6'(len), 2'(ch)};
      x = hdr;
      for (int i = 0; i < n; i++) begin
        pl[i] = 8'($urandom_range(0, 255));
        x = x ^ pl[i];
      end
      if ($urandom_range(0, 2) == 0) x = x ^ 8'h5A;
      run_packet(hdr, n, x);
    end
    rand_bp = 1'b0;
    cycle();
    fifo_full = 1'b0;
    repeat (4) cycle();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
